clkcfg_sequencer: RTL and testbench

Clock-configuration sequencer placed between the core's `cfg` register and the clock generator on the board top level. It watches the core's requested clock mode and applies changes to the clock generator safely. To do so it gates the cog clock, loads the new configuration and waits for PLL lock/settle when the PLL is newly enabled. It also generates the core reset at power-up and on software reset requests (`cfg[7]`).

---
 rtl/clkcfg_sequencer_if.sv | 37 +++
 rtl/clkcfg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_clkcfg_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clkcfg_sequencer_if.sv
// clkcfg_sequencer_if
//   Groups the signals between the core cfg register, the clock-configuration
//   sequencer and the clock generator.
//   cfg_req    [7:0] core cfg (bit 7 reset request, bit 6 PLLENA, bits 2:0 CLKSEL)
//   pll_locked       PLL lock flag from the clock generator
//   cfg_out    [6:0] configuration applied to the clock generator
//   cog_clk_en       cog clock enable
//   core_res         active-high core reset
//   busy             sequencer is not idle
//   master: drives requests/lock, observes results (board top / environment)
//   slave : the sequencer itself
interface clkcfg_sequencer_if;
    logic [7:0] cfg_req;
    logic       pll_locked;
    logic [6:0] cfg_out;
    logic       cog_clk_en;
    logic       core_res;
    logic       busy;

    modport master (
        output cfg_req,
        output pll_locked,
        input  cfg_out,
        input  cog_clk_en,
        input  core_res,
        input  busy
    );

    modport slave (
        input  cfg_req,
        input  pll_locked,
        output cfg_out,
        output cog_clk_en,
        output core_res,
        output busy
    );
endinterface

// File: rtl/clkcfg_sequencer.sv
// clkcfg_sequencer
//   Applies core clock-mode requests to the clock generator safely: gates the
//   cog clock, loads the new configuration, waits for PLL settle/lock when the
//   PLL is newly enabled, then re-enables the cog clock. Also generates the
//   core reset at power-up and on software reset requests (cfg bit 7).
//   Ports:
//     clock_160  single clock, rising edge
//     res        asynchronous active-high reset
//     cfg_bus    slave side of clkcfg_sequencer_if (cfg_req, pll_locked in;
//                cfg_out, cog_clk_en, core_res, busy out - all registered)
module clkcfg_sequencer #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16000,
    parameter int RESET_CYCLES  = 16,
    parameter int CNT_W         = 16
) (
    input  logic                 clock_160,
    input  logic                 res,
    clkcfg_sequencer_if.slave    cfg_bus
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GATE   = 3'd2,
        ST_APPLY  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_RESUME = 3'd5,
        ST_SWRES  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       cfg_q_r;
    logic [6:0]       cfg_tgt_r, cfg_tgt_s;
    logic [6:0]       cfg_out_r, cfg_out_s;
    logic             cog_clk_en_r, cog_clk_en_s;
    logic             core_res_r, core_res_s;
    logic             busy_r, busy_s;
    logic             boot_hold_r;
    logic             cnt_zero_s;

    assign cnt_zero_s = (cnt_r == CNT_ZERO);

    // State, counter, input register and all registered outputs.
    // boot_hold_r registers the release of res so the boot count starts one
    // edge after release, giving the full RESET_CYCLES of core reset.
    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            state_r      <= ST_BOOT;
            cnt_r        <= RESET_LOAD;
            cfg_q_r      <= 8'h00;
            cfg_tgt_r    <= 7'h00;
            cfg_out_r    <= 7'h00;
            cog_clk_en_r <= 1'b0;
            core_res_r   <= 1'b1;
            busy_r       <= 1'b1;
            boot_hold_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            cfg_q_r      <= cfg_bus.cfg_req;
            cfg_tgt_r    <= cfg_tgt_s;
            cfg_out_r    <= cfg_out_s;
            cog_clk_en_r <= cog_clk_en_s;
            core_res_r   <= core_res_s;
            busy_r       <= busy_s;
            boot_hold_r  <= 1'b0;
        end
    end

    // Next-state and next-output logic of the sequencing FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        cfg_tgt_s    = cfg_tgt_r;
        cfg_out_s    = cfg_out_r;
        cog_clk_en_s = cog_clk_en_r;
        core_res_s   = core_res_r;

        case (state_r)
            ST_BOOT: begin
                if (boot_hold_r) begin
                    cnt_s = cnt_r;
                end else if (cnt_zero_s) begin
                    state_s      = ST_IDLE;
                    core_res_s   = 1'b0;
                    cog_clk_en_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            ST_IDLE: begin
                // Software reset has priority over a pending cfg change.
                if (cfg_q_r[7]) begin
                    state_s      = ST_SWRES;
                    core_res_s   = 1'b1;
                    cnt_s        = RESET_LOAD;
                    cfg_out_s    = 7'h00;
                    cog_clk_en_s = 1'b1;
                end else if (cfg_q_r[6:0] != cfg_out_r) begin
                    // Snapshot the target here; later requests wait for IDLE.
                    state_s      = ST_GATE;
                    cog_clk_en_s = 1'b0;
                    cnt_s        = GATE_LOAD;
                    cfg_tgt_s    = cfg_q_r[6:0];
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_GATE: begin
                if (cnt_zero_s) begin
                    state_s = ST_APPLY;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            ST_APPLY: begin
                cfg_out_s = cfg_tgt_r;
                // Settle only on an off-to-on PLLENA transition.
                if (cfg_tgt_r[6] && !cfg_out_r[6]) begin
                    state_s = ST_SETTLE;
                    cnt_s   = SETTLE_LOAD;
                end else begin
                    state_s = ST_RESUME;
                end
            end

            ST_SETTLE: begin
                // Counter holds at zero; no timeout on a missing lock.
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (cfg_bus.pll_locked) begin
                    state_s = ST_RESUME;
                end else begin
                    state_s = ST_SETTLE;
                end
            end

            ST_RESUME: begin
                cog_clk_en_s = 1'b1;
                state_s      = ST_IDLE;
            end

            ST_SWRES: begin
                if (cnt_zero_s) begin
                    core_res_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            default: begin
                // Unreachable encoding: recover through a full boot.
                state_s      = ST_BOOT;
                cnt_s        = RESET_LOAD;
                cfg_out_s    = 7'h00;
                cog_clk_en_s = 1'b0;
                core_res_s   = 1'b1;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    assign cfg_bus.cfg_out    = cfg_out_r;
    assign cfg_bus.cog_clk_en = cog_clk_en_r;
    assign cfg_bus.core_res   = core_res_r;
    assign cfg_bus.busy       = busy_r;

endmodule

// File: tb/tb_clkcfg_sequencer.sv
// tb_clkcfg_sequencer
//   Directed bench for clkcfg_sequencer with GATE=4, SETTLE=20, RESET=16.
//   Edge E0 is the first rising edge after an input is driven; outputs are
//   sampled 1 time unit after each rising edge.
module tb_clkcfg_sequencer;

    localparam int RC = 16;
    localparam int GC = 4;
    localparam int SC = 20;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    clkcfg_sequencer_if bus ();

    clkcfg_sequencer #(
        .GATE_CYCLES   (GC),
        .SETTLE_CYCLES (SC),
        .RESET_CYCLES  (RC),
        .CNT_W         (16)
    ) dut (
        .clock_160 (clk),
        .res       (res),
        .cfg_bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_cfg_out"},    32'(bus.cfg_out),    32'h00);
        check_val({tag, "_cog_clk_en"}, 32'(bus.cog_clk_en), 32'h0);
        check_val({tag, "_core_res"},   32'(bus.core_res),   32'h1);
        check_val({tag, "_busy"},       32'(bus.busy),       32'h1);
    endtask

    // Releases res and measures how many edges core_res stays high.
    task automatic boot_check(input string tag);
        int n_high;
        n_high = 0;
        res = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.core_res) n_high++;
            else break;
        end
        check_val({tag, "_core_res_edges"}, 32'(n_high), 32'(RC));
        check_val({tag, "_cog_clk_en"},     32'(bus.cog_clk_en), 32'h1);
        check_val({tag, "_busy"},           32'(bus.busy),       32'h0);
        check_val({tag, "_cfg_out"},        32'(bus.cfg_out),    32'h00);
    endtask

    // Drives a cfg, optionally raises lock before edge E(lock_at), and
    // returns the edge index at which cog_clk_en comes back (-1 if never).
    task automatic run_seq(input logic [7:0] cfg, input int lock_at, output int rise_at);
        rise_at = -1;
        bus.cfg_req = cfg;
        for (int k = 0; k < 200; k++) begin
            if (k == lock_at) bus.pll_locked = 1'b1;
            tick();
            if (k >= 1 && bus.cog_clk_en) begin
                rise_at = k;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] en_hist;
        logic [7:0] busy_hist;
        logic [6:0] cfg_a, cfg_b;
        logic       en_a, en_b, en_c, c_a, c_b, c_c, b_a;
        int         r, n_high, first_high, en_low;
        bit         done;

        bus.cfg_req    = 8'h00;
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        boot_check("boot");

        // CLKSEL-only change: gated E1..E6, cfg_out at E6, idle at E7
        bus.cfg_req = 8'h01;
        en_hist = 8'h00; busy_hist = 8'h00; cfg_a = 7'h7F; cfg_b = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            tick();
            en_hist[k]   = bus.cog_clk_en;
            busy_hist[k] = bus.busy;
            if (k == 5) cfg_a = bus.cfg_out;
            if (k == 6) cfg_b = bus.cfg_out;
        end
        check_val("clksel_en_hist",   32'(en_hist),   32'h81);
        check_val("clksel_busy_hist", 32'(busy_hist), 32'h7E);
        check_val("clksel_cfg_e5",    32'(cfg_a),     32'h00);
        check_val("clksel_cfg_e6",    32'(cfg_b),     32'h01);

        // PLL enable, lock seen at E40 -> RESUME at E40, enable at E41
        bus.pll_locked = 1'b0;
        run_seq(8'h6B, 40, r);
        check_val("pll_late_rise", 32'(r), 32'd41);
        check_val("pll_late_cfg",  32'(bus.cfg_out), 32'h6B);
        check_val("pll_late_busy", 32'(bus.busy),    32'h0);

        // PLL off: no settle, enable back at E7
        run_seq(8'h03, -1, r);
        check_val("pll_off_rise", 32'(r), 32'd7);
        check_val("pll_off_cfg",  32'(bus.cfg_out), 32'h03);

        // PLL re-enable with early lock: settle count governs (E26 resume)
        bus.pll_locked = 1'b0;
        run_seq(8'h6B, 5, r);
        check_val("pll_early_rise", 32'(r), 32'd27);

        // Software reset pulse: 0x80 for 3 cycles then 0x00
        bus.cfg_req = 8'h80;
        n_high = 0; first_high = -1; en_low = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 3) bus.cfg_req = 8'h00;
            tick();
            if (bus.core_res) begin
                n_high++;
                if (first_high < 0) first_high = k;
            end
            if (!bus.cog_clk_en) en_low++;
        end
        check_val("swres_len",    32'(n_high),      32'd16);
        check_val("swres_first",  32'(first_high),  32'd1);
        check_val("swres_en_low", 32'(en_low),      32'd0);
        check_val("swres_cfg",    32'(bus.cfg_out), 32'h00);
        check_val("swres_busy",   32'(bus.busy),    32'h0);

        // Held reset request: SWRES exits at E17 and re-enters at E18
        bus.cfg_req = 8'h80;
        c_a = 1'b0; c_b = 1'b1; c_c = 1'b0; b_a = 1'b1;
        for (int k = 0; k < 19; k++) begin
            tick();
            if (k == 16) c_a = bus.core_res;
            if (k == 17) begin c_b = bus.core_res; b_a = bus.busy; end
            if (k == 18) c_c = bus.core_res;
        end
        check_val("swhold_e16", 32'(c_a), 32'h1);
        check_val("swhold_e17", 32'(c_b), 32'h0);
        check_val("swhold_busy_e17", 32'(b_a), 32'h0);
        check_val("swhold_e18", 32'(c_c), 32'h1);
        bus.cfg_req = 8'h00;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!bus.busy && !bus.core_res) begin
                done = 1'b1;
                break;
            end
        end
        check_val("swhold_release", 32'(done), 32'h1);

        // Change during GATE: 0x02 applied first, then 0x05
        bus.cfg_req = 8'h02;
        cfg_a = 7'h7F; cfg_b = 7'h7F; en_a = 1'b0; en_b = 1'b1; en_c = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) bus.cfg_req = 8'h05;
            tick();
            if (k == 6)  cfg_a = bus.cfg_out;
            if (k == 7)  en_a  = bus.cog_clk_en;
            if (k == 8)  en_b  = bus.cog_clk_en;
            if (k == 13) cfg_b = bus.cfg_out;
            if (k == 14) en_c  = bus.cog_clk_en;
        end
        check_val("midgate_first_cfg", 32'(cfg_a), 32'h02);
        check_val("midgate_en_e7",     32'(en_a),  32'h1);
        check_val("midgate_en_e8",     32'(en_b),  32'h0);
        check_val("midgate_final_cfg", 32'(cfg_b), 32'h05);
        check_val("midgate_en_e14",    32'(en_c),  32'h1);

        // Reset request together with a cfg change: SWRES wins
        bus.cfg_req = 8'h81;
        tick();
        tick();
        check_val("simul_core_res", 32'(bus.core_res),   32'h1);
        check_val("simul_en",       32'(bus.cog_clk_en), 32'h1);
        check_val("simul_cfg",      32'(bus.cfg_out),    32'h00);
        bus.cfg_req = 8'h01;
        repeat (40) tick();
        check_val("simul_after_cfg",  32'(bus.cfg_out),  32'h01);
        check_val("simul_after_busy", 32'(bus.busy),     32'h0);
        check_val("simul_after_res",  32'(bus.core_res), 32'h0);

        // Asynchronous reset during SETTLE
        bus.pll_locked = 1'b0;
        bus.cfg_req    = 8'h41;
        repeat (10) tick();
        check_val("settle_busy", 32'(bus.busy),       32'h1);
        check_val("settle_en",   32'(bus.cog_clk_en), 32'h0);
        res = 1'b1;
        #1;
        check_reset_vals("async_res");
        bus.cfg_req = 8'h00;
        repeat (2) tick();
        boot_check("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
